// File: rtl/pc_unit.sv
// Program counter for the RV32I single-cycle core.
// Boot hold, stall, jump/branch redirect, trap entry/return and misaligned-target trapping.
module pc_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned     BOOT_CYCLES  = 4,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            Branch,
    input  logic            b_result,
    input  logic [XLEN-1:0] branch_address,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_address,
    input  logic            trap_req,
    input  logic            mret,
    output logic [XLEN-1:0] address_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            pc_valid,
    output logic [XLEN-1:0] epc_out,
    output logic [1:0]      cause_out,
    output logic            misalign_err
);

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    localparam int unsigned     CntW     = (BOOT_CYCLES > 0) ? $clog2(BOOT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] BootInit = CntW'(BOOT_CYCLES);
    localparam state_e          StReset  = (BOOT_CYCLES == 0) ? StRun : StBoot;
    localparam logic [XLEN-1:0] TrapVec  = {TRAP_VECTOR[XLEN-1:2], 2'b00};

    localparam logic [1:0] CauseNone     = 2'd0;
    localparam logic [1:0] CauseTrap     = 2'd1;
    localparam logic [1:0] CauseMisalign = 2'd2;

    if (XLEN < 8) begin : gen_xlen_check
        $error("pc_unit: XLEN must be at least 8");
    end
    if (RESET_VECTOR[1:0] != 2'b00) begin : gen_rv_check
        $error("pc_unit: RESET_VECTOR must be word aligned");
    end

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [1:0]      cause_q, cause_d;
    logic            mis_q, mis_d;

    logic            redirect;
    logic [XLEN-1:0] target;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StReset;
            cnt_q   <= BootInit;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: leave boot on the edge where the counter hits zero
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StBoot: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end
                if (cnt_q <= CntW'(1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: begin
                state_d = StReset;
            end
        endcase
    end

    // Output decode
    always_comb begin
        pc_valid = (state_q == StRun);
    end

    assign redirect = jump || (Branch && b_result);
    assign target   = jump ? jump_address : branch_address;

    // Next-PC selection; strict priority trap > mret > redirect > stall > increment
    always_comb begin
        pc_d    = pc_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        mis_d   = 1'b0;
        if (state_q == StRun) begin
            if (trap_req) begin
                pc_d    = TrapVec;
                epc_d   = pc_q;
                cause_d = CauseTrap;
            end else if (mret) begin
                pc_d    = epc_q;
                cause_d = CauseNone;
            end else if (redirect) begin
                if (target[1:0] != 2'b00) begin
                    pc_d    = TrapVec;
                    epc_d   = pc_q;
                    cause_d = CauseMisalign;
                    mis_d   = 1'b1;
                end else begin
                    pc_d = target;
                end
            end else if (!stall) begin
                pc_d = pc_q + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            cause_q <= CauseNone;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            mis_q   <= mis_d;
        end
    end

    assign address_out  = pc_q;
    assign pc_plus4     = pc_q + XLEN'(4);
    assign epc_out      = epc_q;
    assign cause_out    = cause_q;
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: per-scenario tasks with an expected-value queue.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, Branch, b_result, jump, trap_req, mret;
    logic [31:0] branch_address, jump_address;
    logic [31:0] address_out, pc_plus4, epc_out;
    logic        pc_valid, misalign_err;
    logic [1:0]  cause_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stl;
        logic        br;
        logic        bres;
        logic [31:0] baddr;
        logic        jmp;
        logic [31:0] jaddr;
        logic        trap;
        logic        ret;
    } stim_t;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] epc;
        logic [1:0]  cause;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];

    pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .BOOT_CYCLES  (4),
        .TRAP_VECTOR  (32'h0000_0100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .Branch         (Branch),
        .b_result       (b_result),
        .branch_address (branch_address),
        .jump           (jump),
        .jump_address   (jump_address),
        .trap_req       (trap_req),
        .mret           (mret),
        .address_out    (address_out),
        .pc_plus4       (pc_plus4),
        .pc_valid       (pc_valid),
        .epc_out        (epc_out),
        .cause_out      (cause_out),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(logic stl, logic br, logic bres, logic [31:0] baddr,
                                 logic jmp, logic [31:0] jaddr, logic trap, logic ret);
        stim_t s;
        s.stl = stl; s.br = br; s.bres = bres; s.baddr = baddr;
        s.jmp = jmp; s.jaddr = jaddr; s.trap = trap; s.ret = ret;
        return s;
    endfunction

    function automatic exp_t ex(string name, logic [31:0] addr, logic valid, logic [31:0] epc,
                                logic [1:0] cause, logic mis);
        exp_t e;
        e.name = name; e.addr = addr; e.valid = valid; e.epc = epc; e.cause = cause; e.mis = mis;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        stall = s.stl; Branch = s.br; b_result = s.bres; branch_address = s.baddr;
        jump = s.jmp; jump_address = s.jaddr; trap_req = s.trap; mret = s.ret;
    endtask

    task automatic test_reset;
        logic [99:0] got, want;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        #12;
        got  = {address_out, pc_plus4, pc_valid, epc_out, cause_out, misalign_err};
        want = {32'h0, 32'h4, 1'b0, 32'h0, 2'd0, 1'b0};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL reset: got %h need %h", got, want);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_boot;
        stim_t s[$];
        exp_t  x[$];
        exp_t  e;
        logic [99:0] got, want;
        for (int i = 0; i < 3; i++) begin
            s.push_back(mk(0, 1, 1, 32'h40, 0, 0, 0, 0));
            x.push_back(ex("boot_hold", 32'h0, 1'b0, 32'h0, 2'd0, 1'b0));
        end
        s.push_back(mk(0, 1, 1, 32'h40, 0, 0, 0, 0));
        x.push_back(ex("boot_exit", 32'h0, 1'b1, 32'h0, 2'd0, 1'b0));
        for (int i = 1; i <= 4; i++) begin
            s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
            x.push_back(ex("sequential", 32'(4 * i), 1'b1, 32'h0, 2'd0, 1'b0));
        end
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(x[i]);
            @(posedge clk); #1;
            e    = exp_q.pop_front();
            got  = {address_out, pc_plus4, pc_valid, epc_out, cause_out, misalign_err};
            want = {e.addr, e.addr + 32'd4, e.valid, e.epc, e.cause, e.mis};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s step %0d: got pc=%h p4=%h v=%b epc=%h cause=%0d mis=%b need pc=%h v=%b epc=%h cause=%0d mis=%b",
                         e.name, i, address_out, pc_plus4, pc_valid, epc_out, cause_out,
                         misalign_err, e.addr, e.valid, e.epc, e.cause, e.mis);
            end
        end
    endtask

    task automatic test_branch_stall;
        stim_t s[$];
        exp_t  x[$];
        exp_t  e;
        logic [99:0] got, want;
        s.push_back(mk(1, 1, 1, 32'h40, 0, 0, 0, 0)); x.push_back(ex("br_over_stall", 32'h40, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0)); x.push_back(ex("stall_hold", 32'h40, 1, 0, 0, 0));
        end
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));       x.push_back(ex("after_stall", 32'h44, 1, 0, 0, 0));
        s.push_back(mk(0, 1, 0, 32'h80, 0, 0, 0, 0));  x.push_back(ex("br_not_taken", 32'h48, 1, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 32'h20, 0, 0));  x.push_back(ex("jump", 32'h20, 1, 0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(x[i]);
            @(posedge clk); #1;
            e    = exp_q.pop_front();
            got  = {address_out, pc_plus4, pc_valid, epc_out, cause_out, misalign_err};
            want = {e.addr, e.addr + 32'd4, e.valid, e.epc, e.cause, e.mis};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got pc=%h p4=%h v=%b epc=%h cause=%0d mis=%b need pc=%h epc=%h cause=%0d mis=%b",
                         e.name, address_out, pc_plus4, pc_valid, epc_out, cause_out,
                         misalign_err, e.addr, e.epc, e.cause, e.mis);
            end
        end
    endtask

    task automatic test_priority;
        stim_t s[$];
        exp_t  x[$];
        exp_t  e;
        logic [99:0] got, want;
        s.push_back(mk(0, 0, 0, 0, 1, 32'h80, 1, 0)); x.push_back(ex("trap_over_jump", 32'h100, 1, 32'h20, 1, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));      x.push_back(ex("mret", 32'h20, 1, 32'h20, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 32'h30, 0, 0)); x.push_back(ex("jump_0x30", 32'h30, 1, 32'h20, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(x[i]);
            @(posedge clk); #1;
            e    = exp_q.pop_front();
            got  = {address_out, pc_plus4, pc_valid, epc_out, cause_out, misalign_err};
            want = {e.addr, e.addr + 32'd4, e.valid, e.epc, e.cause, e.mis};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got pc=%h epc=%h cause=%0d mis=%b need pc=%h epc=%h cause=%0d mis=%b",
                         e.name, address_out, epc_out, cause_out, misalign_err,
                         e.addr, e.epc, e.cause, e.mis);
            end
        end
    endtask

    task automatic test_misalign;
        stim_t s[$];
        exp_t  x[$];
        exp_t  e;
        logic [99:0] got, want;
        s.push_back(mk(0, 0, 0, 0, 1, 32'h52, 0, 0)); x.push_back(ex("mis_jump", 32'h100, 1, 32'h30, 2, 1));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));      x.push_back(ex("mis_pulse_end", 32'h104, 1, 32'h30, 2, 0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(x[i]);
            @(posedge clk); #1;
            e    = exp_q.pop_front();
            got  = {address_out, pc_plus4, pc_valid, epc_out, cause_out, misalign_err};
            want = {e.addr, e.addr + 32'd4, e.valid, e.epc, e.cause, e.mis};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got pc=%h epc=%h cause=%0d mis=%b need pc=%h epc=%h cause=%0d mis=%b",
                         e.name, address_out, epc_out, cause_out, misalign_err,
                         e.addr, e.epc, e.cause, e.mis);
            end
        end
    endtask

    task automatic test_back_to_back;
        stim_t s[$];
        exp_t  x[$];
        exp_t  e;
        logic [99:0] got, want;
        s.push_back(mk(0, 1, 1, 32'h41, 0, 0, 0, 0)); x.push_back(ex("mis_br_1", 32'h100, 1, 32'h104, 2, 1));
        s.push_back(mk(0, 1, 1, 32'h43, 0, 0, 0, 0)); x.push_back(ex("mis_br_2", 32'h100, 1, 32'h100, 2, 1));
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));      x.push_back(ex("mis_clear", 32'h100, 1, 32'h100, 2, 0));
        s.push_back(mk(0, 0, 0, 0, 1, 32'h300, 0, 1)); x.push_back(ex("mret_over_jump", 32'h100, 1, 32'h100, 0, 0));
        s.push_back(mk(0, 1, 1, 32'h400, 1, 32'h200, 0, 0)); x.push_back(ex("jump_over_br", 32'h200, 1, 32'h100, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(x[i]);
            @(posedge clk); #1;
            e    = exp_q.pop_front();
            got  = {address_out, pc_plus4, pc_valid, epc_out, cause_out, misalign_err};
            want = {e.addr, e.addr + 32'd4, e.valid, e.epc, e.cause, e.mis};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got pc=%h epc=%h cause=%0d mis=%b need pc=%h epc=%h cause=%0d mis=%b",
                         e.name, address_out, epc_out, cause_out, misalign_err,
                         e.addr, e.epc, e.cause, e.mis);
            end
        end
    endtask

    task automatic test_wrap;
        stim_t s[$];
        exp_t  x[$];
        exp_t  e;
        logic [99:0] got, want;
        s.push_back(mk(0, 1, 1, 32'hFFFF_FFF8, 0, 0, 0, 0));
        x.push_back(ex("wrap_f8", 32'hFFFF_FFF8, 1, 32'h100, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(ex("wrap_fc", 32'hFFFF_FFFC, 1, 32'h100, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(ex("wrap_0", 32'h0, 1, 32'h100, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(ex("wrap_4", 32'h4, 1, 32'h100, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(x[i]);
            @(posedge clk); #1;
            e    = exp_q.pop_front();
            got  = {address_out, pc_plus4, pc_valid, epc_out, cause_out, misalign_err};
            want = {e.addr, e.addr + 32'd4, e.valid, e.epc, e.cause, e.mis};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got pc=%h p4=%h epc=%h cause=%0d need pc=%h p4=%h epc=%h cause=%0d",
                         e.name, address_out, pc_plus4, epc_out, cause_out,
                         e.addr, e.addr + 32'd4, e.epc, e.cause);
            end
        end
    endtask

    task automatic test_async_reset;
        stim_t s[$];
        exp_t  x[$];
        exp_t  e;
        logic [99:0] got, want;
        drive(mk(0, 0, 0, 0, 1, 32'h44, 0, 0));
        exp_q.push_back(ex("pre_reset", 32'h44, 1, 32'h100, 0, 0));
        @(posedge clk); #1;
        e    = exp_q.pop_front();
        got  = {address_out, pc_plus4, pc_valid, epc_out, cause_out, misalign_err};
        want = {e.addr, e.addr + 32'd4, e.valid, e.epc, e.cause, e.mis};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h need %h", e.name, got, want);
        end
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        #1 rst = 1'b0;
        #1;
        got  = {address_out, pc_plus4, pc_valid, epc_out, cause_out, misalign_err};
        want = {32'h0, 32'h4, 1'b0, 32'h0, 2'd0, 1'b0};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL async_reset: got %h need %h", got, want);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s.push_back(mk(0, 1, 1, 32'h40, 0, 0, 0, 0));
            x.push_back(ex("reboot_hold", 32'h0, 0, 32'h0, 0, 0));
        end
        s.push_back(mk(0, 0, 0, 0, 1, 32'h80, 0, 0)); x.push_back(ex("reboot_exit", 32'h0, 1, 32'h0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));      x.push_back(ex("reboot_run", 32'h4, 1, 32'h0, 0, 0));
        for (int i = 0; i < s.size(); i++) begin
            drive(s[i]);
            exp_q.push_back(x[i]);
            @(posedge clk); #1;
            e    = exp_q.pop_front();
            got  = {address_out, pc_plus4, pc_valid, epc_out, cause_out, misalign_err};
            want = {e.addr, e.addr + 32'd4, e.valid, e.epc, e.cause, e.mis};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s step %0d: got pc=%h v=%b epc=%h cause=%0d mis=%b need pc=%h v=%b epc=%h",
                         e.name, i, address_out, pc_valid, epc_out, cause_out, misalign_err,
                         e.addr, e.valid, e.epc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_boot();
        test_branch_stall();
        test_priority();
        test_misalign();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
